// File: rtl/fill_shift_seq.sv
// Iterative handshaked left-shifter for fill literals ('0/'1/'x), producing a data + X-mask pair.
// Optional macro FILL_SHIFT_RIGHT_EN adds in_dir (0=left, 1=logical right).
module fill_shift_seq #(
  parameter int WIDTH = 64,
  parameter int AMTW  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_fill,
  input  logic [AMTW-1:0]  in_amt,
`ifdef FILL_SHIFT_RIGHT_EN
  input  logic             in_dir,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [WIDTH-1:0] out_xmask
);

  localparam int LOGW = $clog2(WIDTH);
  localparam int KW   = (LOGW > 1) ? $clog2(LOGW) : 1;

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t           state_q, state_d;
  logic [KW-1:0]    k_q;
  logic [LOGW-1:0]  amt_q;
  logic [WIDTH-1:0] data_q, xmask_q;
  logic [WIDTH-1:0] data_sh, xmask_sh;
  logic             accept, last_iter, oversize;
`ifdef FILL_SHIFT_RIGHT_EN
  logic             dir_q;
`endif

  assign accept    = in_valid && in_ready;
  assign last_iter = (k_q == KW'(LOGW - 1));
  // Any amount bit at or above LOGW pushes every bit out of the word.
  assign oversize  = (in_amt >> LOGW) != '0;

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)    state_d = RUN;
      RUN:     if (last_iter) state_d = HOLD;
      HOLD:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE) && !rst;
    out_valid = (state_q == HOLD);
  end

  // One shift stage per cycle: stage k moves by 2**k when amount bit k is set.
  always_comb begin
    data_sh  = data_q;
    xmask_sh = xmask_q;
    for (int i = 0; i < LOGW; i++) begin
      if (k_q == KW'(i) && amt_q[i]) begin
`ifdef FILL_SHIFT_RIGHT_EN
        if (dir_q) begin
          data_sh  = data_q  >> (1 << i);
          xmask_sh = xmask_q >> (1 << i);
        end else begin
          data_sh  = data_q  << (1 << i);
          xmask_sh = xmask_q << (1 << i);
        end
`else
        data_sh  = data_q  << (1 << i);
        xmask_sh = xmask_q << (1 << i);
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      k_q     <= '0;
      amt_q   <= '0;
      data_q  <= '0;
      xmask_q <= '0;
`ifdef FILL_SHIFT_RIGHT_EN
      dir_q   <= 1'b0;
`endif
    end else if (accept) begin
      k_q   <= '0;
      amt_q <= in_amt[LOGW-1:0];
`ifdef FILL_SHIFT_RIGHT_EN
      dir_q <= in_dir;
`endif
      // Oversize loads the known-zero word; the RUN phase still takes LOGW cycles.
      if (oversize) begin
        data_q  <= '0;
        xmask_q <= '0;
      end else begin
        case (in_fill)
          2'b00: begin data_q <= '0; xmask_q <= '0; end
          2'b01: begin data_q <= '1; xmask_q <= '0; end
          default: begin data_q <= '0; xmask_q <= '1; end
        endcase
      end
    end else if (state_q == RUN) begin
      data_q  <= data_sh;
      xmask_q <= xmask_sh;
      k_q     <= last_iter ? '0 : k_q + KW'(1);
    end
  end

  assign out_data  = data_q;
  assign out_xmask = xmask_q;

endmodule

// File: tb/tb_fill_shift_seq.sv
// Self-checking bench for fill_shift_seq: per-cycle transaction model plus directed literal vectors.
module tb_fill_shift_seq;

  localparam int WIDTH = 64;
  localparam int AMTW  = 8;
  localparam int LOGW  = 6;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [1:0]       in_fill = 2'b00;
  logic [AMTW-1:0]  in_amt = '0;
  logic             in_dir = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] out_data, out_xmask;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  fill_shift_seq #(.WIDTH(WIDTH), .AMTW(AMTW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_fill   (in_fill),
    .in_amt    (in_amt),
`ifdef FILL_SHIFT_RIGHT_EN
    .in_dir    (in_dir),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_xmask (out_xmask)
  );

  task automatic check(input string name, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // Expected result straight from the definition: fill word shifted by amt in one step.
  function automatic void model(input logic [1:0] f, input int amt, input logic dir,
                                output logic [WIDTH-1:0] d, output logic [WIDTH-1:0] x);
    case (f)
      2'b00:   begin d = '0; x = '0; end
      2'b01:   begin d = '1; x = '0; end
      default: begin d = '0; x = '1; end
    endcase
    if (amt >= WIDTH) begin
      d = '0;
      x = '0;
    end else if (dir) begin
      d = d >> amt;
      x = x >> amt;
    end else begin
      d = d << amt;
      x = x << amt;
    end
  endfunction

  // Transaction-level model: idle, or busy with a count of edges since accept.
  bit               mon_en    = 1'b0;
  bit               busy      = 1'b0;
  bit               after_rst = 1'b0;
  int               since     = 0;
  logic [WIDTH-1:0] m_data, m_xmask;

  always @(negedge clk) begin
    if (mon_en) begin
      check("invariant", out_data & out_xmask, '0);
      check("m_in_ready", 64'(in_ready), 64'(!busy && !rst));
      check("m_out_valid", 64'(out_valid), 64'(busy && since >= LOGW));
      if (busy && since >= LOGW) begin
        check("m_out_data", out_data, m_data);
        check("m_out_xmask", out_xmask, m_xmask);
      end
      if (after_rst) begin
        check("m_rst_data", out_data, '0);
        check("m_rst_xmask", out_xmask, '0);
      end
      if (rst) begin
        busy      = 1'b0;
        after_rst = 1'b1;
      end else if (!busy) begin
        if (in_valid) begin
          busy      = 1'b1;
          since     = 0;
          after_rst = 1'b0;
          model(in_fill, int'(in_amt), in_dir, m_data, m_xmask);
        end
      end else if (since >= LOGW) begin
        if (out_ready) busy = 1'b0;
      end else begin
        since++;
      end
    end
  end

  // Called at posedge+2; returns at posedge+2 after the output handshake (or in HOLD if out_ready=0).
  task automatic do_req(input logic [1:0] f, input logic [7:0] a, input logic d, input bit pin,
                        input logic [WIDTH-1:0] ed, input logic [WIDTH-1:0] ex, input string name);
    int w;
    int lat;
    w = 0;
    while (!in_ready && w < 20) begin
      @(posedge clk); #2;
      w++;
    end
    check({name, "_ready"}, 64'(in_ready), 64'd1);
    in_fill  = f;
    in_amt   = a;
    in_dir   = d;
    in_valid = 1'b1;
    @(posedge clk); #2;
    in_valid = 1'b0;
    in_fill  = 2'($urandom);
    in_amt   = 8'($urandom);
    in_dir   = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #2;
      lat++;
    end
    check({name, "_lat"}, 64'(lat), 64'(LOGW));
    if (pin) begin
      check({name, "_data"}, out_data, ed);
      check({name, "_xmask"}, out_xmask, ex);
    end
    if (out_ready) begin
      @(posedge clk); #2;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0] rf;
    logic [7:0] ra;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", out_data, '0);
    check("rst_out_xmask", out_xmask, '0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    rst = 1'b0;
    mon_en = 1'b1;
    #1;
    check("rel_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #2;

    do_req(2'b01, 8'd8,   1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FF00, 64'h0, "one_a8");
    do_req(2'b10, 8'd8,   1'b0, 1'b1, 64'h0, 64'hFFFF_FFFF_FFFF_FF00, "x_a8");
    do_req(2'b11, 8'd8,   1'b0, 1'b1, 64'h0, 64'hFFFF_FFFF_FFFF_FF00, "rsv_a8");
    do_req(2'b00, 8'd8,   1'b0, 1'b1, 64'h0, 64'h0, "zero_a8");
    do_req(2'b01, 8'd0,   1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, "one_a0");
    do_req(2'b01, 8'd63,  1'b0, 1'b1, 64'h8000_0000_0000_0000, 64'h0, "one_a63");
    do_req(2'b01, 8'd64,  1'b0, 1'b1, 64'h0, 64'h0, "one_a64");
    do_req(2'b01, 8'd255, 1'b0, 1'b1, 64'h0, 64'h0, "one_a255");
    do_req(2'b10, 8'd1,   1'b0, 1'b1, 64'h0, 64'hFFFF_FFFF_FFFF_FFFE, "x_a1");
    do_req(2'b01, 8'd32,  1'b0, 1'b1, 64'hFFFF_FFFF_0000_0000, 64'h0, "one_a32");
    do_req(2'b10, 8'd63,  1'b0, 1'b1, 64'h0, 64'h8000_0000_0000_0000, "x_a63");
    do_req(2'b10, 8'd128, 1'b0, 1'b1, 64'h0, 64'h0, "x_a128");
    do_req(2'b01, 8'd65,  1'b0, 1'b1, 64'h0, 64'h0, "one_a65");
    do_req(2'b01, 8'd42,  1'b0, 1'b1, 64'hFFFF_FC00_0000_0000, 64'h0, "one_a42");

    // Backpressure: hold the result for three cycles, then release.
    out_ready = 1'b0;
    do_req(2'b01, 8'd8, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FF00, 64'h0, "bp");
    repeat (3) begin
      @(posedge clk); #2;
      check("bp_hold_valid", 64'(out_valid), 64'd1);
      check("bp_hold_data", out_data, 64'hFFFF_FFFF_FFFF_FF00);
      check("bp_hold_xmask", out_xmask, 64'h0);
      check("bp_hold_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #2;
    check("bp_rel_valid", 64'(out_valid), 64'd0);
    check("bp_rel_in_ready", 64'(in_ready), 64'd1);
    do_req(2'b00, 8'd1, 1'b0, 1'b1, 64'h0, 64'h0, "bp_next");

    // Reset while RUN is at iteration k=3.
    in_fill  = 2'b01;
    in_amt   = 8'd8;
    in_dir   = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #2;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk); #2;
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_data", out_data, '0);
    check("mid_rst_xmask", out_xmask, '0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd0);
    rst = 1'b0;
    #1;
    check("mid_rel_in_ready", 64'(in_ready), 64'd1);
    repeat (10) begin
      @(posedge clk); #2;
      check("no_stale_valid", 64'(out_valid), 64'd0);
    end

`ifdef FILL_SHIFT_RIGHT_EN
    do_req(2'b01, 8'd8,  1'b1, 1'b1, 64'h00FF_FFFF_FFFF_FFFF, 64'h0, "r_one_a8");
    do_req(2'b10, 8'd4,  1'b1, 1'b1, 64'h0, 64'h0FFF_FFFF_FFFF_FFFF, "r_x_a4");
    do_req(2'b01, 8'd64, 1'b1, 1'b1, 64'h0, 64'h0, "r_one_a64");
`endif

    // Extra vectors checked only by the model.
    for (int i = 0; i < 8; i++) begin
      rf = 2'($urandom);
      ra = (i % 2 == 0) ? 8'($urandom_range(0, 63)) : 8'($urandom);
      do_req(rf, ra, 1'b0, 1'b0, '0, '0, "mdl");
    end

    repeat (3) @(posedge clk);
    #2;
    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
